// File: rtl/dht11_responder.sv
// DHT11 responder: answers a host start pulse with the ack handshake and a 40-bit frame on an open-drain bus.
// Reset is synchronous. Outputs decode from the state, so the bus is released on the first reset edge.
module dht11_responder #(
  parameter int unsigned START_MIN_LOW = 1_000_000,
  parameter int unsigned RESP_DELAY    = 3000,
  parameter int unsigned RESP_LOW      = 8000,
  parameter int unsigned RESP_HIGH     = 8000,
  parameter int unsigned BIT_LOW       = 5000,
  parameter int unsigned BIT_HIGH_0    = 2700,
  parameter int unsigned BIT_HIGH_1    = 7000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] hum_int_i,
  input  logic [7:0] hum_dec_i,
  input  logic [7:0] temp_int_i,
  input  logic [7:0] temp_dec_i,
  input  logic       corrupt_cs_i,
  input  logic       dht11_data_i,
  output logic       dht11_data_o,
  output logic       dht11_data_o_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_count
);

  // Each phase ends on the cycle its counter reaches length-1.
  localparam logic [20:0] L_START = 21'(START_MIN_LOW - 1);
  localparam logic [20:0] L_RD    = 21'(RESP_DELAY - 1);
  localparam logic [20:0] L_RL    = 21'(RESP_LOW - 1);
  localparam logic [20:0] L_RH    = 21'(RESP_HIGH - 1);
  localparam logic [20:0] L_BL    = 21'(BIT_LOW - 1);
  localparam logic [20:0] L_H0    = 21'(BIT_HIGH_0 - 1);
  localparam logic [20:0] L_H1    = 21'(BIT_HIGH_1 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_WAIT_RELEASE, S_RESP_DELAY, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW, S_WAIT_HIGH
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2;
  logic [20:0] r_cnt;
  logic [20:0] w_high_last;
  logic [5:0]  r_bit_idx;
  logic [39:0] r_tx;
  logic [7:0]  r_sh_hi, r_sh_hd, r_sh_ti, r_sh_td;
  logic        r_sh_cor;
  logic [7:0]  w_cs;
  logic        r_done;
  logic [7:0]  r_frame_count;
  logic        w_bus;
  logic        w_frame_end;

  assign w_bus        = r_sync2;
  assign w_cs         = (r_sh_hi + r_sh_hd + r_sh_ti + r_sh_td) ^ {7'd0, r_sh_cor};
  assign w_high_last  = r_tx[r_bit_idx] ? L_H1 : L_H0;
  assign w_frame_end  = (r_state == S_END_LOW) && (w_state_nxt == S_WAIT_HIGH);
  assign dht11_data_o = 1'b0;
  assign done         = r_done;
  assign frame_count  = r_frame_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    dht11_data_o_en = 1'b0;
    busy            = 1'b0;
    case (r_state)
      S_IDLE:         if (!w_bus) w_state_nxt = S_START_LOW;
      S_START_LOW: begin
        if (w_bus)                 w_state_nxt = S_IDLE;
        else if (r_cnt == L_START) w_state_nxt = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: if (w_bus) w_state_nxt = S_RESP_DELAY;
      S_RESP_DELAY:   if (r_cnt == L_RD) w_state_nxt = S_RESP_LOW;
      S_RESP_LOW: begin
        dht11_data_o_en = 1'b1;
        busy            = 1'b1;
        if (r_cnt == L_RL) w_state_nxt = S_RESP_HIGH;
      end
      S_RESP_HIGH: begin
        busy = 1'b1;
        if (r_cnt == L_RH) w_state_nxt = S_BIT_LOW;
      end
      S_BIT_LOW: begin
        dht11_data_o_en = 1'b1;
        busy            = 1'b1;
        if (r_cnt == L_BL) w_state_nxt = S_BIT_HIGH;
      end
      S_BIT_HIGH: begin
        busy = 1'b1;
        if (r_cnt == w_high_last)
          w_state_nxt = (r_bit_idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
      end
      S_END_LOW: begin
        dht11_data_o_en = 1'b1;
        busy            = 1'b1;
        if (r_cnt == L_BL) w_state_nxt = S_WAIT_HIGH;
      end
      // Hold here until the bus is seen high so a stuck-low line cannot retrigger.
      S_WAIT_HIGH:    if (w_bus) w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_tx          <= '0;
      r_sh_hi       <= '0;
      r_sh_hd       <= '0;
      r_sh_ti       <= '0;
      r_sh_td       <= '0;
      r_sh_cor      <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_sync1 <= dht11_data_i;
      r_sync2 <= r_sync1;

      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != '1)       r_cnt <= r_cnt + 21'd1;

      if (load) begin
        r_sh_hi  <= hum_int_i;
        r_sh_hd  <= hum_dec_i;
        r_sh_ti  <= temp_int_i;
        r_sh_td  <= temp_dec_i;
        r_sh_cor <= corrupt_cs_i;
      end

      // Snapshot uses the pre-load shadow values if load coincides with release.
      if (r_state == S_WAIT_RELEASE && w_state_nxt == S_RESP_DELAY)
        r_tx <= {r_sh_hi, r_sh_hd, r_sh_ti, r_sh_td, w_cs};

      if (r_state == S_RESP_HIGH)
        r_bit_idx <= 6'd39;
      else if (r_state == S_BIT_HIGH && w_state_nxt == S_BIT_LOW)
        r_bit_idx <= r_bit_idx - 6'd1;

      r_done <= w_frame_end;
      if (w_frame_end) r_frame_count <= r_frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder with scaled-down phase lengths; host and responder share a modelled pull-up bus.
`timescale 1ns/1ps
module tb_dht11_responder;
  localparam int SML = 10, RD = 6, RL = 8, RH = 8, BL = 3, H0 = 1, H1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, cor_i, host_low, bus;
  logic [7:0] hi_i, hd_i, ti_i, td_i;
  logic       dout, oen, busy, done;
  logic [7:0] fcnt;

  assign bus = ~(host_low | oen);

  dht11_responder #(
    .START_MIN_LOW(SML), .RESP_DELAY(RD), .RESP_LOW(RL), .RESP_HIGH(RH),
    .BIT_LOW(BL), .BIT_HIGH_0(H0), .BIT_HIGH_1(H1)
  ) dut (
    .clk(clk), .rst(rst), .load(load),
    .hum_int_i(hi_i), .hum_dec_i(hd_i), .temp_int_i(ti_i), .temp_dec_i(td_i),
    .corrupt_cs_i(cor_i), .dht11_data_i(bus), .dht11_data_o(dout),
    .dht11_data_o_en(oen), .busy(busy), .done(done), .frame_count(fcnt)
  );

  int total = 0, bad = 0, done_cnt = 0, exp_count = 0;
  logic [7:0]  m_sh [4];
  logic        m_cor;
  logic [39:0] m_tx;

  int          c_gap, c_rl, c_rh, c_end, c_tbad;
  logic [39:0] c_bits;
  logic        c_done, c_busy_mid, c_busy_end;
  logic [7:0]  c_fc;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference: bytes MSB first, checksum = byte sum mod 256, optionally flipped in bit 0.
  function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d, input logic cr);
    int s;
    logic [7:0] cs;
    s  = int'(a) + int'(b) + int'(c) + int'(d);
    cs = 8'(s % 256);
    if (cr) cs = cs ^ 8'h01;
    return {a, b, c, d, cs};
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0; m_sh[3] = 0; m_cor = 1'b0;
    exp_count = 0;
  endtask

  task automatic do_load(input logic [7:0] a, b, c, d, input logic cr);
    @(negedge clk);
    hi_i = a; hd_i = b; ti_i = c; td_i = d; cor_i = cr; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_sh[0] = a; m_sh[1] = b; m_sh[2] = c; m_sh[3] = d; m_cor = cr;
  endtask

  task automatic host_start(input int hold);
    host_low = 1'b0;
    repeat (4) @(negedge clk);
    host_low = 1'b1;
    repeat (hold) @(negedge clk);
    host_low = 1'b0;
    m_tx = model_frame(m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_cor);
  endtask

  task automatic run_len(input logic lvl, output int n);
    logic go;
    n = 1; go = 1'b1;
    while (go) begin
      @(negedge clk);
      if (oen === lvl && n < 200) n++;
      else go = 1'b0;
    end
  endtask

  task automatic wait_oen(input logic lvl, output logic ok);
    int n;
    n = 0;
    while (oen !== lvl && n < 300) begin @(negedge clk); n++; end
    ok = (oen === lvl);
  endtask

  // Measures one response as run lengths of the drive enable, starting at the release edge.
  task automatic capture();
    int lo, hi;
    c_gap = 0; c_rl = 0; c_rh = 0; c_end = 0; c_tbad = 0; c_bits = '0;
    c_done = 1'b0; c_busy_mid = 1'b0; c_busy_end = 1'b1; c_fc = 8'hxx;
    while (oen !== 1'b1 && c_gap < 300) begin @(negedge clk); c_gap++; end
    if (oen !== 1'b1) begin c_tbad = 1000; return; end
    c_busy_mid = busy;
    run_len(1'b1, c_rl);
    run_len(1'b0, c_rh);
    for (int i = 0; i < 40; i++) begin
      run_len(1'b1, lo);
      run_len(1'b0, hi);
      if (lo != BL) c_tbad++;
      if (hi == H1)      c_bits[39-i] = 1'b1;
      else if (hi != H0) c_tbad++;
    end
    run_len(1'b1, c_end);
    c_done = done; c_fc = fcnt; c_busy_end = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; host_low = 1'b0; cor_i = 1'b0;
    hi_i = 0; hd_i = 0; ti_i = 0; td_i = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0; m_sh[3] = 0; m_cor = 1'b0; exp_count = 0;
    @(negedge clk);
    total++; if (oen !== 1'b0) begin bad++; $display("FAIL reset_oen got=%b want=0", oen); end
    total++; if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b want=0", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (fcnt !== 8'd0) begin bad++; $display("FAIL reset_fcnt got=%0d want=0", fcnt); end
  endtask

  task automatic test_nominal();
    int d0;
    do_load(8'h37, 8'h00, 8'h18, 8'h00, 1'b0);
    d0 = done_cnt;
    host_start(18);
    capture();
    exp_count++;
    repeat (3) @(negedge clk);
    total++; if (c_gap < RD + 1 || c_gap > RD + 3) begin bad++; $display("FAIL nom_ack_latency got=%0d want=%0d..%0d", c_gap, RD + 1, RD + 3); end
    total++; if (c_rl != RL) begin bad++; $display("FAIL nom_ack_low got=%0d want=%0d", c_rl, RL); end
    total++; if (c_rh != RH) begin bad++; $display("FAIL nom_ack_high got=%0d want=%0d", c_rh, RH); end
    total++; if (c_bits !== 40'h370018004F) begin bad++; $display("FAIL nom_frame got=%h want=370018004f", c_bits); end
    total++; if (c_tbad != 0) begin bad++; $display("FAIL nom_bit_timing got=%0d bad phases want=0", c_tbad); end
    total++; if (c_end != BL) begin bad++; $display("FAIL nom_end_low got=%0d want=%0d", c_end, BL); end
    total++; if (c_done !== 1'b1) begin bad++; $display("FAIL nom_done_at_release got=%b want=1", c_done); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL nom_done_pulses got=%0d want=1", done_cnt - d0); end
    total++; if (c_fc !== 8'(exp_count)) begin bad++; $display("FAIL nom_fcnt got=%0d want=%0d", c_fc, exp_count); end
    total++; if (c_busy_mid !== 1'b1 || c_busy_end !== 1'b0) begin bad++; $display("FAIL nom_busy got=%b%b want=10", c_busy_mid, c_busy_end); end
  endtask

  task automatic test_short_start();
    int seen;
    seen = 0;
    host_start(5);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (oen !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL short_no_response got=%0d active cycles want=0", seen); end
    total++; if (fcnt !== 8'(exp_count)) begin bad++; $display("FAIL short_fcnt got=%0d want=%0d", fcnt, exp_count); end
  endtask

  task automatic test_corrupt();
    do_load(8'h37, 8'h00, 8'h18, 8'h00, 1'b1);
    host_start(18); capture(); exp_count++;
    total++; if (c_bits !== 40'h370018004E) begin bad++; $display("FAIL corrupt_cs got=%h want=370018004e", c_bits); end
    do_load(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
    host_start(18); capture(); exp_count++;
    total++; if (c_bits !== 40'hFFFF010201) begin bad++; $display("FAIL wrap_cs got=%h want=ffff010201", c_bits); end
    total++; if (c_fc !== 8'(exp_count)) begin bad++; $display("FAIL corrupt_fcnt got=%0d want=%0d", c_fc, exp_count); end
  endtask

  task automatic test_load_mid_frame();
    do_load(8'h37, 8'h00, 8'h18, 8'h00, 1'b0);
    host_start(18);
    fork
      capture();
      begin
        repeat (RD + 3 + RL + RH + 10 * (BL + 2)) @(negedge clk);
        do_load(8'h50, 8'h05, 8'h20, 8'h02, 1'b0);
      end
    join
    exp_count++;
    total++; if (c_bits !== 40'h370018004F) begin bad++; $display("FAIL midload_current got=%h want=370018004f", c_bits); end
    host_start(18); capture(); exp_count++;
    total++; if (c_bits !== 40'h5005200277) begin bad++; $display("FAIL midload_next got=%h want=5005200277", c_bits); end
  endtask

  task automatic test_reset_mid_bit();
    logic ok1, ok2, ok3, ok4;
    do_load(8'h80, 8'h11, 8'h22, 8'h33, 1'b0);
    host_start(18);
    wait_oen(1'b1, ok1); wait_oen(1'b0, ok2); wait_oen(1'b1, ok3); wait_oen(1'b0, ok4);
    total++; if (!(ok1 && ok2 && ok3 && ok4)) begin bad++; $display("FAIL rstmid_reach_bit got=%b%b%b%b want=1111", ok1, ok2, ok3, ok4); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0; m_sh[3] = 0; m_cor = 1'b0; exp_count = 0;
    total++; if (oen !== 1'b0) begin bad++; $display("FAIL rstmid_oen got=%b want=0", oen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (fcnt !== 8'd0) begin bad++; $display("FAIL rstmid_fcnt got=%0d want=0", fcnt); end
    host_start(18); capture(); exp_count++;
    total++; if (c_bits !== 40'h0) begin bad++; $display("FAIL rstmid_zero_frame got=%h want=0000000000", c_bits); end
  endtask

  task automatic test_held_low();
    int seen;
    seen = 0;
    do_reset();
    do_load(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    host_start(18); capture(); exp_count++;
    host_low = 1'b1;
    for (int i = 0; i < 5 * SML; i++) begin
      @(negedge clk);
      if (oen !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL held_no_retrigger got=%0d active cycles want=0", seen); end
    total++; if (fcnt !== 8'd1) begin bad++; $display("FAIL held_fcnt1 got=%0d want=1", fcnt); end
    host_start(18); capture(); exp_count++;
    total++; if (c_bits !== m_tx) begin bad++; $display("FAIL held_second_frame got=%h want=%h", c_bits, m_tx); end
    total++; if (c_fc !== 8'd2) begin bad++; $display("FAIL held_fcnt2 got=%0d want=2", c_fc); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, c, d;
    logic       cr, mid;
    for (int it = 0; it < 6; it++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      cr = 1'($urandom_range(0, 1));
      do_load(a, b, c, d, cr);
      host_start($urandom_range(SML + 3, 3 * SML));
      mid = 1'($urandom_range(0, 1));
      fork
        capture();
        begin
          if (mid) begin
            repeat ($urandom_range(5, 150)) @(negedge clk);
            do_load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          end
        end
      join
      exp_count++;
      total++; if (c_bits !== m_tx || c_tbad != 0) begin bad++; $display("FAIL rand_frame[%0d] got=%h tbad=%0d want=%h tbad=0", it, c_bits, c_tbad, m_tx); end
      total++; if (c_fc !== 8'(exp_count)) begin bad++; $display("FAIL rand_fcnt[%0d] got=%0d want=%0d", it, c_fc, exp_count); end
    end
  endtask

  task automatic test_count_wrap();
    int zero_bad;
    zero_bad = 0;
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      host_start(SML + 4);
      capture();
      exp_count++;
      if (c_bits !== 40'h0 || c_tbad != 0) zero_bad++;
      if (k == 255) begin
        total++; if (c_fc !== 8'd255) begin bad++; $display("FAIL wrap_fcnt255 got=%0d want=255", c_fc); end
      end
    end
    repeat (3) @(negedge clk);
    total++; if (zero_bad != 0) begin bad++; $display("FAIL wrap_frames got=%0d bad frames want=0", zero_bad); end
    total++; if (fcnt !== 8'd0) begin bad++; $display("FAIL wrap_fcnt0 got=%0d want=0", fcnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_start();
    test_corrupt();
    test_load_mid_frame();
    test_reset_mid_bit();
    test_held_low();
    test_random();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
